// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared 7-segment definitions for the hex-to-segment encoder and the scan
// reader. Both sides take their patterns from SEG_CODES so that the encoder
// and the reader always agree on what a digit looks like.
//
// Segment bit order: bit0=a, bit1=b, ... bit6=g. Patterns are active low,
// so a lit segment is a 0. Literals below are written g..a (MSB first).
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam int SEG_W = 7;

  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_bit_e;

  localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'b0011000;
  localparam logic [SEG_W-1:0] SEG_HEX_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_HEX_B = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_HEX_C = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_HEX_D = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_HEX_E = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_HEX_F = 7'b0001110;

  // All segments dark: no digit shown.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Indexed by nibble value.
  localparam logic [SEG_W-1:0] SEG_CODES [16] = '{
    SEG_HEX_0, SEG_HEX_1, SEG_HEX_2, SEG_HEX_3,
    SEG_HEX_4, SEG_HEX_5, SEG_HEX_6, SEG_HEX_7,
    SEG_HEX_8, SEG_HEX_9, SEG_HEX_A, SEG_HEX_B,
    SEG_HEX_C, SEG_HEX_D, SEG_HEX_E, SEG_HEX_F
  };

  // Encoder direction, shared with the hex-to-segment decoder.
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
    return SEG_CODES[nib];
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// -----------------------------------------------------------------------------
// seg7_to_hex
// Combinational inverse of the hex-to-segment encoder.
//
// Ports:
//   i_seg  [6:0]  active-low segment pattern, bit0=a .. bit6=g
//   o_nib  [3:0]  recovered nibble (0 when the pattern is not a hex digit)
//   o_inv         1 when the pattern matches none of the 16 hex codes
// -----------------------------------------------------------------------------
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nib,
  output logic       o_inv
);

  // The 16 codes are distinct, so at most one entry can match.
  always_comb begin
    o_nib = 4'h0;
    o_inv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i_seg == SEG_CODES[i]) begin
        o_nib = 4'(i);
        o_inv = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// -----------------------------------------------------------------------------
// seg7_scan_reader
// Snoops a multiplexed active-low common-anode 7-segment bus and recovers the
// hex frame being displayed. Each (anode, segment) pair must stay stable for
// STABLE_CYC cycles before it is captured; a frame is emitted once every digit
// has been captured at least once since the previous frame.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_seg  [6:0] segment lines, active low, bit0=a .. bit6=g
//   i_an   [NDIG-1:0] anode enables, active low, one low bit selects a digit
//   o_dat  [4*NDIG-1:0] recovered frame, digit k in bits [4k+3:4k]
//   o_val        one-cycle pulse when o_dat / o_err / o_digit_err update
//   o_err        OR of o_digit_err for the frame
//   o_digit_err [NDIG-1:0] per-digit invalid-pattern flag for the frame
// -----------------------------------------------------------------------------
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [6:0]        i_seg,
  input  logic [NDIG-1:0]   i_an,
  output logic [4*NDIG-1:0] o_dat,
  output logic              o_val,
  output logic              o_err,
  output logic [NDIG-1:0]   o_digit_err
);

  localparam int        BUS_W   = NDIG + SEG_W;
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC - 1);

  logic [BUS_W-1:0]  r_sync_p1;
  logic [BUS_W-1:0]  r_sync_p2;
  logic [7:0]        r_cnt;
  logic              r_done;
  logic [NDIG-1:0]   r_mask;
  logic [4*NDIG-1:0] r_shadow;
  logic [NDIG-1:0]   r_shadow_err;

  logic              w_same;
  logic [NDIG-1:0]   w_an_sel;
  logic              w_one_low;
  logic              w_capture;
  logic [3:0]        w_nib;
  logic              w_inv;
  logic [4*NDIG-1:0] w_shadow_nx;
  logic [NDIG-1:0]   w_err_nx;
  logic [NDIG-1:0]   w_mask_nx;
  logic              w_frame;

  // ---- stage p1/p2: two-flop synchronizer on the whole bus ----
  // Reset value is all ones: blank segments, no anode selected.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync_p1 <= '1;
      r_sync_p2 <= '1;
    end else begin
      r_sync_p1 <= {i_an, i_seg};
      r_sync_p2 <= r_sync_p1;
    end
  end

  assign w_same   = (r_sync_p1 == r_sync_p2);
  assign w_an_sel = ~r_sync_p2[BUS_W-1:SEG_W];

  // Exactly one anode low: non-zero and a power of two after inversion.
  assign w_one_low = (w_an_sel != '0) &&
                     ((w_an_sel & (w_an_sel - NDIG'(1))) == '0);

  seg7_to_hex u_dec (
    .i_seg (r_sync_p2[SEG_W-1:0]),
    .o_nib (w_nib),
    .o_inv (w_inv)
  );

  // One capture per stable dwell: r_done blocks repeats until the bus changes.
  assign w_capture = w_same && (r_cnt == CNT_MAX) && !r_done && w_one_low;

  always_comb begin
    w_shadow_nx = r_shadow;
    w_err_nx    = r_shadow_err;
    w_mask_nx   = r_mask;
    if (w_capture) begin
      for (int k = 0; k < NDIG; k++) begin
        if (w_an_sel[k]) begin
          w_shadow_nx[4*k +: 4] = w_nib;
          w_err_nx[k]           = w_inv;
          w_mask_nx[k]          = 1'b1;
        end
      end
    end
    w_frame = w_capture && (&w_mask_nx);
  end

  // ---- stage p3: stability counter, digit shadows and frame output ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= 8'd0;
      r_done       <= 1'b0;
      r_mask       <= '0;
      r_shadow     <= '0;
      r_shadow_err <= '0;
      o_dat        <= '0;
      o_val        <= 1'b0;
      o_err        <= 1'b0;
      o_digit_err  <= '0;
    end else begin
      if (!w_same) begin
        r_cnt  <= 8'd0;
        r_done <= 1'b0;
      end else begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 8'd1;
        if (w_capture)        r_done <= 1'b1;
      end

      r_shadow     <= w_shadow_nx;
      r_shadow_err <= w_err_nx;
      r_mask       <= w_frame ? '0 : w_mask_nx;
      o_val        <= w_frame;

      // Outputs hold between frames; the completing digit is included.
      if (w_frame) begin
        o_dat       <= w_shadow_nx;
        o_digit_err <= w_err_nx;
        o_err       <= |w_err_nx;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
module tb_seg7_scan_reader;

  localparam int NDIG       = 4;
  localparam int STABLE_CYC = 8;

  // Reference segment table, written out independently of the design package.
  localparam logic [6:0] REF [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [6:0]  i_seg;
  logic [3:0]  i_an;
  logic [15:0] o_dat;
  logic        o_val;
  logic        o_err;
  logic [3:0]  o_digit_err;

  int n_checks = 0;
  int n_err    = 0;
  int pulses   = 0;
  int p;

  // Model state
  logic [10:0] m_last   = '1;
  int          m_run    = 0;
  logic [15:0] m_shadow = '0;
  logic [3:0]  m_serr   = '0;
  logic [3:0]  m_mask   = '0;
  logic [15:0] m_dat    = '0;
  logic [3:0]  m_derr   = '0;
  logic        m_err    = 1'b0;
  logic        m_val    = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_reader #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC)) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_seg       (i_seg),
    .i_an        (i_an),
    .o_dat       (o_dat),
    .o_val       (o_val),
    .o_err       (o_err),
    .o_digit_err (o_digit_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (REF[i] == s) return {1'b0, 4'(i)};
    return {1'b1, 4'h0};
  endfunction

  function automatic int zeros(input logic [3:0] an);
    int c = 0;
    for (int i = 0; i < 4; i++) if (!an[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    m_last = '1; m_run = 0; m_shadow = '0; m_serr = '0; m_mask = '0;
    m_dat = '0; m_derr = '0; m_err = 1'b0; m_val = 1'b0;
  endtask

  // A pair seen on STABLE_CYC+1 consecutive sampling edges is captured on the
  // following edge; one capture per run of identical samples.
  task automatic model_step();
    logic [4:0]  d;
    logic [10:0] cur;
    m_val = 1'b0;
    if (m_run == STABLE_CYC + 1 && zeros(m_last[10:7]) == 1) begin
      d = ref_decode(m_last[6:0]);
      for (int k = 0; k < 4; k++) begin
        if (!m_last[7+k]) begin
          m_shadow[4*k +: 4] = d[3:0];
          m_serr[k]          = d[4];
          m_mask[k]          = 1'b1;
        end
      end
      if (&m_mask) begin
        m_dat  = m_shadow;
        m_derr = m_serr;
        m_err  = |m_serr;
        m_val  = 1'b1;
        m_mask = '0;
      end
    end
    cur = {i_an, i_seg};
    if (cur == m_last) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_last = cur;
      m_run  = 1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge i_rst_n);
      if (!i_rst_n) model_reset();
      else          model_step();
    end
  end

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_val",  32'(o_val),       32'(m_val));
      check("cyc_dat",  32'(o_dat),       32'(m_dat));
      check("cyc_err",  32'(o_err),       32'(m_err));
      check("cyc_derr", 32'(o_digit_err), 32'(m_derr));
      if (o_val) pulses++;
    end
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    i_an  = an;
    i_seg = seg;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_an    = 4'hF;
    i_seg   = 7'h7F;
    repeat (3) @(posedge clk);
    #2;
    check("rst_dat",  32'(o_dat), 32'h0);
    check("rst_val",  32'(o_val), 32'h0);
    check("rst_derr", 32'(o_digit_err), 32'h0);
    i_rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Basic scan: 1234
    p = pulses;
    drive(4'b1110, 7'b0011001, 20);
    drive(4'b1101, 7'b0110000, 20);
    drive(4'b1011, 7'b0100100, 20);
    drive(4'b0111, 7'b1111001, 20);
    check("scan_pulses", 32'(pulses - p), 32'd1);
    check("scan_dat",    32'(o_dat), 32'h1234);
    check("scan_err",    32'(o_err), 32'h0);
    check("scan_derr",   32'(o_digit_err), 32'h0);

    // Latency of the completing digit
    drive(4'b1110, REF[7], 12);
    drive(4'b1101, REF[8], 12);
    drive(4'b1011, REF[9], 12);
    drive(4'b0111, REF[15], 9);
    check("lat_edge9_val", 32'(o_val), 32'h0);
    drive(4'b0111, REF[15], 1);
    check("lat_edge10_val", 32'(o_val), 32'h1);
    check("lat_nib",        32'(o_dat[15:12]), 32'hF);
    check("lat_dat",        32'(o_dat), 32'hF987);
    drive(4'b0111, REF[15], 5);

    // Invalid patterns: digit0 0101010, digit1 blank
    drive(4'b1110, 7'b0101010, 12);
    drive(4'b1101, 7'h7F, 12);
    drive(4'b1011, REF[5], 12);
    drive(4'b0111, REF[10], 12);
    check("inv_derr", 32'(o_digit_err), 32'h3);
    check("inv_err",  32'(o_err), 32'h1);
    check("inv_lo",   32'(o_dat[7:0]), 32'h00);
    check("inv_dat",  32'(o_dat), 32'hA500);

    // Glitch and overlapping anodes
    p = pulses;
    drive(4'b1110, REF[12], 12);
    drive(4'b1101, REF[13], 12);
    drive(4'b0111, REF[14], 12);
    drive(4'b1011, REF[8], 5);
    drive(4'b1100, REF[8], 30);
    check("glitch_no_val", 32'(pulses - p), 32'd0);
    drive(4'b1011, REF[7], 12);
    check("glitch_val", 32'(pulses - p), 32'd1);
    check("glitch_dat", 32'(o_dat), 32'hE7DC);

    // Recapture: digit0 shows 5 then 9
    p = pulses;
    drive(4'b1110, REF[5], 12);
    drive(4'b1110, REF[9], 12);
    drive(4'b1101, REF[0], 12);
    drive(4'b1011, REF[6], 12);
    drive(4'b0111, REF[15], 12);
    check("recap_pulses", 32'(pulses - p), 32'd1);
    check("recap_nib",    32'(o_dat[3:0]), 32'h9);
    check("recap_dat",    32'(o_dat), 32'hF609);

    // Reset mid-frame
    drive(4'b1110, REF[1], 12);
    drive(4'b1101, REF[2], 12);
    i_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mrst_dat",  32'(o_dat), 32'h0);
    check("mrst_val",  32'(o_val), 32'h0);
    check("mrst_err",  32'(o_err), 32'h0);
    check("mrst_derr", 32'(o_digit_err), 32'h0);
    i_rst_n = 1'b1;
    p = pulses;
    drive(4'b1011, REF[5], 12);
    drive(4'b0111, REF[6], 12);
    check("mrst_partial", 32'(pulses - p), 32'd0);
    drive(4'b1110, REF[3], 12);
    drive(4'b1101, REF[4], 12);
    check("mrst_pulses", 32'(pulses - p), 32'd1);
    check("mrst_frame",  32'(o_dat), 32'h6543);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
Observes a multiplexed, active-low common-anode 7-segment display bus (segment lines plus per-digit anode enables) and recovers the hex value shown on it. Inverse of the team's hex-to-7-segment decoder. Used as a loop-back checker and display-snooping front end in lab designs. Filters scan glitches, decodes each digit's pattern to a nibble, assembles a full frame and emits a one-cycle valid pulse with error flags.

Parameters:
NDIG, 4, number of multiplexed digits (1..8)
STABLE_CYC, 8, cycles a (anode, segment) pair must be stable before capture (2..255)

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_seg  input  7  segment lines, active low; bit0=a .. bit6=g
i_an  input  NDIG  digit anode enables, active low, one-hot-low when valid
o_dat  output  4*NDIG  recovered frame; digit k in bits [4k+3:4k]
o_val  output  1  one-cycle pulse: o_dat/o_err/o_digit_err updated
o_err  output  1  OR of o_digit_err for the frame
o_digit_err  output  NDIG  per-digit invalid-pattern flag for the frame

Behaviour:
- Reset (asynchronous, i_rst_n=0): o_dat=0, o_val=0, o_err=0, o_digit_err=0; sync stages set to all ones (blank, no digit selected); counter=0; capture mask=0; done flag=0; digit shadow registers=0.
- Inputs pass through 2-flop synchronizer (sync1 -> sync2) on the concatenated {i_an, i_seg}.
- Stability counter: if sync1 != sync2, counter<=0 and done<=0; else counter increments, saturating at STABLE_CYC-1.
- Capture condition, evaluated on pre-edge values: sync1==sync2, counter==STABLE_CYC-1, done==0, and sync2 anode field has exactly one bit low. On capture: done<=1; shadow digit k (index of the low anode bit) <= decoded nibble; shadow error bit k <= invalid flag; mask bit k <= 1.
- Anode field all ones or more than one bit low: no capture; counter still runs; done is unaffected.
- Decode: the 16 codes 0..F are the team's standard active-low patterns (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110). Any other pattern, including blank 1111111, gives nibble 0 with the invalid flag set.
- Latency: count the edge that first loads a new input value into sync1 as edge 1. Capture occurs on edge STABLE_CYC+2.
- Recapture: the same digit captured again before frame completion overwrites its shadow nibble and error bit; latest wins.
- Frame completion: when the capture edge makes the mask all ones, on that same edge:
  - o_dat <= shadow, including the new digit;
  - o_digit_err <= shadow error, including the new bit; o_err <= OR of those bits;
  - o_val <= 1; mask <= 0.
- o_val is 0 on every other edge. o_dat and error outputs hold between frames.
- A glitch shorter than STABLE_CYC cycles is never captured.
- Reset mid-frame discards the partial mask and shadows. The first frame after reset requires all NDIG digits to be captured anew.

Decomposition:
- seg7_pkg: the 16 segment-code constants, SEG_BLANK=7'h7F, and the segment bit-order definition. The existing hex-to-segment decoder must use the same constants so encoder and reader cannot diverge.
- Sub-module seg7_to_hex: combinational 7-bit pattern -> 4-bit nibble plus invalid flag.
- Everything else (synchronizer, stability counter, one-hot check, mask/shadow, frame output) stays in seg7_scan_reader.

Test Plan:
- NDIG=4, STABLE_CYC=8. Scan an=1110/seg=0011001, an=1101/seg=0110000, an=1011/seg=0100100, an=0111/seg=1111001, each held 20 cycles -> exactly one o_val pulse, o_dat=16'h1234, o_err=0, o_digit_err=4'b0000.
- Latency: after reset, hold all digits long enough for the first three to be captured, then drive digit3=0001110 from a known edge -> o_val high after edge 10 counted from the sync1-load edge, o_dat[15:12]=4'hF.
- Digit1 driven 1111111 (blank) and digit0 driven 0101010 in a full scan -> o_val with o_digit_err=4'b0011, o_err=1, o_dat[7:0]=8'h00.
- Glitch and overlap: digit2 pattern held only 5 cycles, then an=1100 held 30 cycles -> no capture of digit2 and no o_val until a clean 10-cycle digit2 dwell.
- Recapture: digit0 shows 5, then 9, both before digit3 is captured -> o_dat[3:0]=4'h9.
- Reset mid-frame: assert i_rst_n=0 after two digits are captured, release, scan four digits -> all outputs 0 during reset; single o_val carrying only the post-reset values.
